// File: rtl/eth_tx_pkg.sv
// Shared Ethernet TX constants, byte-wide CRC-32 helper and ARP responder state encoding.
package eth_tx_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IP    = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH    = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IP     = 8'h04;
    localparam logic [15:0] ARP_OPER_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY  = 16'h0002;
    localparam int          ETH_MIN_PAYLOAD = 60;

    localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_FCS  = 3'd3,
        ST_IFG  = 3'd4
    } arp_tx_state_t;

    // Reflected CRC-32, data bits consumed LSB first as they appear on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register: init reloads, en folds in one byte; shared by TX FCS generation and RX checking.
module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data_in);
        end
    end

endmodule

// File: rtl/arp_reply_tx.sv
// GMII transmit-side ARP responder: one request pulse -> one padded ARP reply frame with FCS.
// Optional gratuitous ARP support is compiled in with ARP_TX_GARP_EN.
module arp_reply_tx
    import eth_tx_pkg::*;
#(
    parameter int IFG_CYCLES   = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [47:0] mac_s_addr,
    input  logic [31:0] ip_s_addr,
    input  logic [47:0] rq_mac_addr,
    input  logic [31:0] rq_ip_addr,
    input  logic        arp_req,
`ifdef ARP_TX_GARP_EN
    input  logic        garp_req,
`endif
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_PRE  = ST_PRE;
    localparam logic [2:0] S_DATA = ST_DATA;
    localparam logic [2:0] S_FCS  = ST_FCS;
    localparam logic [2:0] S_IFG  = ST_IFG;

    logic [2:0]   state, next_state;
    logic [5:0]   cnt, next_cnt;
    logic         start, any_pend;
    logic         rq_pend;
    logic [47:0]  rq_mac_q, act_mac;
    logic [31:0]  rq_ip_q, act_ip;
    logic         act_garp;
    logic [7:0]   next_byte, data_byte;
    logic [31:0]  crc, fcs;
    logic [335:0] hdr;
    logic [5:0]   hdr_idx;
    logic [47:0]  dst_mac, tha_mac;
    logic [31:0]  tpa_ip;
    logic [15:0]  oper;

    // Request strobes carry no ready: every pulse is accepted into its pending slot
    // (latest overwrites), and busy reports a frame in progress or a request queued.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rq_pend <= 1'b0;
        end else if (arp_req) begin
            rq_pend <= 1'b1;
        end else if (start && rq_pend) begin
            rq_pend <= 1'b0;
        end
    end

`ifdef ARP_TX_GARP_EN
    logic garp_pend;

    always_ff @(posedge aclk) begin
        if (areset) begin
            garp_pend <= 1'b0;
        end else if (garp_req) begin
            garp_pend <= 1'b1;
        end else if (start && !rq_pend) begin
            garp_pend <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (start) act_garp <= !rq_pend;
    end

    assign any_pend = rq_pend | garp_pend;
`else
    assign act_garp = 1'b0;
    assign any_pend = rq_pend;
`endif

    // The in-flight frame reads only act_*, so new requests cannot disturb it.
    always_ff @(posedge aclk) begin
        if (arp_req) begin
            rq_mac_q <= rq_mac_addr;
            rq_ip_q  <= rq_ip_addr;
        end
        if (start) begin
            act_mac <= rq_mac_q;
            act_ip  <= rq_ip_q;
        end
    end

    // An IFG that ends with a request queued goes straight to PRE, so the gap stays IFG_CYCLES.
    always_comb begin
        next_state = state;
        next_cnt   = cnt + 6'd1;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                next_cnt = '0;
                if (any_pend) begin
                    next_state = S_PRE;
                    start      = 1'b1;
                end
            end
            S_PRE: if (cnt == 6'(PREAMBLE_LEN)) begin
                next_state = S_DATA;
                next_cnt   = '0;
            end
            S_DATA: if (cnt == 6'(ETH_MIN_PAYLOAD - 1)) begin
                next_state = S_FCS;
                next_cnt   = '0;
            end
            S_FCS: if (cnt == 6'd3) begin
                next_state = S_IFG;
                next_cnt   = '0;
            end
            S_IFG: if (cnt == 6'(IFG_CYCLES - 1)) begin
                next_cnt = '0;
                if (any_pend) begin
                    next_state = S_PRE;
                    start      = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign dst_mac = act_garp ? 48'hFFFF_FFFF_FFFF : act_mac;
    assign tha_mac = act_garp ? 48'h0 : act_mac;
    assign tpa_ip  = act_garp ? ip_s_addr : act_ip;
    assign oper    = act_garp ? ARP_OPER_REQ : ARP_OPER_REPLY;

    // Bytes 0..41 of the payload, MSB first; everything after is zero padding.
    assign hdr = {dst_mac, mac_s_addr, ETH_TYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IP,
                  ARP_HLEN_ETH, ARP_PLEN_IP, oper, mac_s_addr, ip_s_addr, tha_mac, tpa_ip};
    assign hdr_idx = 6'd41 - next_cnt;
    assign fcs     = ~crc;

    always_comb begin
        data_byte = 8'h00;
        if (next_cnt < 6'd42) data_byte = hdr[{hdr_idx, 3'b000} +: 8];
    end

    always_comb begin
        next_byte = 8'h00;
        case (next_state)
            S_PRE:   next_byte = (next_cnt == 6'(PREAMBLE_LEN)) ? ETH_SFD : ETH_PREAMBLE;
            S_DATA:  next_byte = data_byte;
            S_FCS:   next_byte = fcs[{next_cnt[1:0], 3'b000} +: 8];
            default: next_byte = 8'h00;
        endcase
    end

    crc32_d8 u_crc (
        .clk     (aclk),
        .init    (next_state == S_PRE),
        .en      (next_state == S_DATA),
        .data_in (next_byte),
        .crc     (crc)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            gmii_txd   <= next_byte;
            gmii_tx_en <= (next_state == S_PRE) || (next_state == S_DATA) || (next_state == S_FCS);
        end
    end

    assign gmii_tx_er = 1'b0;
    assign busy       = (state != S_IDLE) || any_pend;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed bench for arp_reply_tx: frame contents, FCS residue, latency, IFG, request merging, reset.
module tb_arp_reply_tx;
    import eth_tx_pkg::*;

    localparam logic [47:0] MAC_S = 48'h02_00_00_00_00_01;
    localparam logic [31:0] IP_S  = 32'hC0A8010A;
    localparam logic [47:0] MAC_A = 48'hAA_BB_CC_DD_EE_FF;
    localparam logic [47:0] MAC_B = 48'h00_11_22_33_44_55;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [47:0] mac_s_addr = MAC_S;
    logic [31:0] ip_s_addr = IP_S;
    logic [47:0] rq_mac_addr = '0;
    logic [31:0] rq_ip_addr = '0;
    logic        arp_req = 1'b0;
`ifdef ARP_TX_GARP_EN
    logic        garp_req = 1'b0;
`endif
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en, gmii_tx_er, busy;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int req_cyc, first_cyc, last_cyc;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    arp_reply_tx dut (
        .aclk        (aclk),
        .areset      (areset),
        .mac_s_addr  (mac_s_addr),
        .ip_s_addr   (ip_s_addr),
        .rq_mac_addr (rq_mac_addr),
        .rq_ip_addr  (rq_ip_addr),
        .arp_req     (arp_req),
`ifdef ARP_TX_GARP_EN
        .garp_req    (garp_req),
`endif
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy)
    );

    // Clock / cycle counter / watchdog
    always #4 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        repeat (60000) @(posedge aclk);
        $display("FAIL watchdog: run still active at cycle %0d, need finish before 60000", cyc);
        $fatal(1, "watchdog expired");
    end

    // Bench-side CRC, written as a per-bit shift with feedback from the incoming data bit.
    function automatic logic [31:0] tb_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Scoreboard: expected wire bytes of one frame, preamble through FCS.
    task automatic push_frame(input logic [47:0] rmac, input logic [31:0] rip, input bit garp);
        logic [7:0]  d[60];
        logic [47:0] dst, tha;
        logic [31:0] tpa, c;
        logic [15:0] op;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        dst = garp ? 48'hFFFF_FFFF_FFFF : rmac;
        tha = garp ? 48'h0 : rmac;
        tpa = garp ? IP_S : rip;
        op  = garp ? 16'h0001 : 16'h0002;
        for (int i = 0; i < 60; i++) d[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            d[i]      = dst[47-8*i -: 8];
            d[6 + i]  = MAC_S[47-8*i -: 8];
            d[22 + i] = MAC_S[47-8*i -: 8];
            d[32 + i] = tha[47-8*i -: 8];
        end
        d[12] = 8'h08; d[13] = 8'h06; d[14] = 8'h00; d[15] = 8'h01;
        d[16] = 8'h08; d[17] = 8'h00; d[18] = 8'h06; d[19] = 8'h04;
        d[20] = op[15:8]; d[21] = op[7:0];
        for (int i = 0; i < 4; i++) begin
            d[28 + i] = IP_S[31-8*i -: 8];
            d[38 + i] = tpa[31-8*i -: 8];
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            exp_q.push_back(d[i]);
            c = tb_crc(c, d[i]);
        end
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [31:0] got_residue();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < got_q.size(); i++) c = tb_crc(c, got_q[i]);
        return c;
    endfunction

    // Driver tasks: inputs change on the falling edge, outputs sampled on the falling edge.
    task automatic drive_req(input logic [47:0] m, input logic [31:0] ip);
        @(negedge aclk);
        rq_mac_addr = m;
        rq_ip_addr  = ip;
        arp_req     = 1'b1;
        req_cyc     = cyc;
        @(negedge aclk);
        arp_req     = 1'b0;
        rq_mac_addr = {$urandom, 16'($urandom_range(0, 65535))};
        rq_ip_addr  = $urandom;
    endtask

    task automatic capture(input int max_wait, output bit timeout);
        int w;
        got_q.delete();
        timeout = 1'b0;
        w = 0;
        while (gmii_tx_en !== 1'b1 && w < max_wait) begin
            @(negedge aclk);
            w++;
        end
        if (gmii_tx_en !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        first_cyc = cyc;
        while (gmii_tx_en === 1'b1 && got_q.size() < 200) begin
            got_q.push_back(gmii_txd);
            last_cyc = cyc;
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            arp_req = 1'($urandom_range(0, 1));
        end
        arp_req = 1'b0;
        @(negedge aclk);
        n_tests++; if (gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b need 0", gmii_tx_en); end
        n_tests++; if (gmii_txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h need 00", gmii_txd); end
        n_tests++; if (gmii_tx_er !== 1'b0) begin n_fail++; $display("FAIL reset_tx_er: got %b need 0", gmii_tx_er); end
        areset = 1'b0;
        repeat (3) @(negedge aclk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_tests++; if (gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle_tx_en: got %b need 0", gmii_tx_en); end
    endtask

    task automatic test_single();
        bit to;
        int d;
        logic [31:0] r;
        push_frame(MAC_A, 32'hC0A80101, 1'b0);
        drive_req(MAC_A, 32'hC0A80101);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_pending: got %b need 1", busy); end
        capture(20, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: tx_en got 0 need 1"); end
        n_tests++; if (first_cyc - req_cyc != 2) begin n_fail++; $display("FAIL single_latency: got %0d need 2", first_cyc - req_cyc); end
        n_tests++; if (got_q.size() != 72) begin n_fail++; $display("FAIL single_tx_en_len: got %0d need 72", got_q.size()); end
        d = first_diff();
        n_tests++; if (d != -1) begin
            n_fail++;
            $display("FAIL single_bytes: byte %0d got %h need %h", d,
                     (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx);
        end
        r = got_residue();
        n_tests++; if (r !== CRC32_RESIDUE) begin n_fail++; $display("FAIL single_residue: got %h need %h", r, CRC32_RESIDUE); end
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        int d1, d2, l1;
        fork
            begin
                drive_req(MAC_A, 32'hC0A80111);
                repeat (3) @(negedge aclk);
                drive_req(MAC_B, 32'hC0A80122);
            end
            begin
                capture(20, to1);
                push_frame(MAC_A, 32'hC0A80111, 1'b0);
                d1 = first_diff();
                l1 = last_cyc;
                capture(40, to2);
                push_frame(MAC_B, 32'hC0A80122, 1'b0);
                d2 = first_diff();
            end
        join
        n_tests++; if (to1 || d1 != -1) begin n_fail++; $display("FAIL b2b_frame1: timeout %b diff byte %0d need no diff", to1, d1); end
        n_tests++; if (to2 || d2 != -1) begin n_fail++; $display("FAIL b2b_frame2: timeout %b diff byte %0d need no diff", to2, d2); end
        n_tests++; if (first_cyc - l1 - 1 != 12) begin n_fail++; $display("FAIL b2b_ifg: got %0d idle cycles need 12", first_cyc - l1 - 1); end
    endtask

    task automatic test_latest_wins();
        bit to1, to2, to3;
        int d1, d2;
        fork
            begin
                drive_req(MAC_A, 32'hC0A80101);
                repeat (2) @(negedge aclk);
                drive_req(MAC_A, 32'hC0A80102);
                repeat (10) @(negedge aclk);
                drive_req(MAC_B, 32'hC0A80103);
            end
            begin
                capture(20, to1);
                push_frame(MAC_A, 32'hC0A80101, 1'b0);
                d1 = first_diff();
            end
        join
        capture(80, to2);
        push_frame(MAC_B, 32'hC0A80103, 1'b0);
        d2 = first_diff();
        capture(120, to3);
        n_tests++; if (to1 || d1 != -1) begin n_fail++; $display("FAIL latest_frame1: timeout %b diff byte %0d need no diff", to1, d1); end
        n_tests++; if (to2 || d2 != -1) begin n_fail++; $display("FAIL latest_frame2: timeout %b diff byte %0d need no diff", to2, d2); end
        n_tests++; if (to3 !== 1'b1) begin n_fail++; $display("FAIL latest_no_third: got extra frame of %0d bytes need none", got_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int w, d;
        logic [31:0] r;
        push_frame(MAC_A, 32'hC0A80155, 1'b0);
        drive_req(MAC_A, 32'hC0A80155);
        w = 0;
        while (gmii_tx_en !== 1'b1 && w < 20) begin @(negedge aclk); w++; end
        repeat (28) @(negedge aclk);
        n_tests++; if (gmii_txd !== exp_q[28] || gmii_tx_en !== 1'b1) begin
            n_fail++; $display("FAIL midrst_byte20: got en %b txd %h need en 1 txd %h", gmii_tx_en, gmii_txd, exp_q[28]);
        end
        areset = 1'b1;
        @(negedge aclk);
        n_tests++; if (gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_en: got %b need 0", gmii_tx_en); end
        n_tests++; if (gmii_txd !== 8'h00) begin n_fail++; $display("FAIL midrst_txd: got %h need 00", gmii_txd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b need 0", busy); end
        areset = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge aclk);
        push_frame(MAC_B, 32'hC0A80166, 1'b0);
        drive_req(MAC_B, 32'hC0A80166);
        capture(20, to);
        d = first_diff();
        r = got_residue();
        n_tests++; if (to || d != -1) begin n_fail++; $display("FAIL midrst_new_frame: timeout %b diff byte %0d need no diff", to, d); end
        n_tests++; if (r !== CRC32_RESIDUE) begin n_fail++; $display("FAIL midrst_residue: got %h need %h", r, CRC32_RESIDUE); end
    endtask

    task automatic test_req_on_start();
        bit to1, to2;
        int d1, d2, l1;
        fork
            begin
                @(negedge aclk);
                rq_mac_addr = MAC_A; rq_ip_addr = 32'hC0A80177; arp_req = 1'b1;
                @(negedge aclk);
                rq_mac_addr = MAC_B; rq_ip_addr = 32'hC0A80188;
                @(negedge aclk);
                arp_req = 1'b0; rq_mac_addr = '0; rq_ip_addr = '0;
            end
            begin
                capture(20, to1);
                push_frame(MAC_A, 32'hC0A80177, 1'b0);
                d1 = first_diff();
                l1 = last_cyc;
                capture(40, to2);
                push_frame(MAC_B, 32'hC0A80188, 1'b0);
                d2 = first_diff();
            end
        join
        n_tests++; if (to1 || d1 != -1) begin n_fail++; $display("FAIL onstart_frame1: timeout %b diff byte %0d need no diff", to1, d1); end
        n_tests++; if (to2 || d2 != -1) begin n_fail++; $display("FAIL onstart_frame2: timeout %b diff byte %0d need no diff", to2, d2); end
        n_tests++; if (first_cyc - l1 - 1 != 12) begin n_fail++; $display("FAIL onstart_ifg: got %0d idle cycles need 12", first_cyc - l1 - 1); end
    endtask

`ifdef ARP_TX_GARP_EN
    task automatic test_garp();
        bit to1, to2;
        int d1, d2, l1;
        fork
            begin
                @(negedge aclk);
                rq_mac_addr = MAC_B; rq_ip_addr = 32'hC0A80199; arp_req = 1'b1; garp_req = 1'b1;
                @(negedge aclk);
                arp_req = 1'b0; garp_req = 1'b0;
            end
            begin
                capture(20, to1);
                push_frame(MAC_B, 32'hC0A80199, 1'b0);
                d1 = first_diff();
                l1 = last_cyc;
                capture(40, to2);
                push_frame(MAC_B, 32'hC0A80199, 1'b1);
                d2 = first_diff();
            end
        join
        n_tests++; if (to1 || d1 != -1) begin n_fail++; $display("FAIL garp_reply_first: timeout %b diff byte %0d need no diff", to1, d1); end
        n_tests++; if (to2 || d2 != -1) begin n_fail++; $display("FAIL garp_frame: timeout %b diff byte %0d need no diff", to2, d2); end
        n_tests++; if (got_residue() !== CRC32_RESIDUE) begin n_fail++; $display("FAIL garp_residue: got %h need %h", got_residue(), CRC32_RESIDUE); end
        n_tests++; if (first_cyc - l1 - 1 != 12) begin n_fail++; $display("FAIL garp_ifg: got %0d idle cycles need 12", first_cyc - l1 - 1); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        repeat (20) @(negedge aclk);
        test_back_to_back();
        repeat (20) @(negedge aclk);
        test_latest_wins();
        repeat (20) @(negedge aclk);
        test_reset_mid_frame();
        repeat (20) @(negedge aclk);
        test_req_on_start();
`ifdef ARP_TX_GARP_EN
        repeat (20) @(negedge aclk);
        test_garp();
`endif
        repeat (20) @(negedge aclk);
        n_tests++; if (busy !== 1'b0 || gmii_tx_en !== 1'b0) begin
            n_fail++; $display("FAIL final_idle: got busy %b tx_en %b need 0 0", busy, gmii_tx_en);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
